// File: rtl/circulant_router_param.sv
// circulant_router_param: buffered node router for the circulant C(N_NODES; S1, S1+1).
// Define ADAPTIVE_ROUTE_EN to let a head blocked on its r1 output take an r2 hop instead.
module circulant_router_param #(
  parameter int  N_NODES = 81,
  parameter int  S1      = 6,
  parameter int  NODE_W  = 7,
  parameter int  STEP_W  = 7,
  parameter int  DATA_W  = 8,
  parameter int  DEPTH   = 4,
  localparam int FLIT_W  = 2*STEP_W + DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NODE_W-1:0]   router_name,
  input  logic                loc_in_valid,
  output logic                loc_in_ready,
  input  logic [NODE_W-1:0]   loc_in_dst,
  input  logic [DATA_W-1:0]   loc_in_payload,
  input  logic [3:0]          link_in_valid,
  output logic [3:0]          link_in_ready,
  input  logic [4*FLIT_W-1:0] link_in_flit,
  output logic [3:0]          link_out_valid,
  input  logic [3:0]          link_out_ready,
  output logic [4*FLIT_W-1:0] link_out_flit,
  output logic                loc_out_valid,
  input  logic                loc_out_ready,
  output logic [DATA_W-1:0]   loc_out_payload
);

  localparam int AW = $clog2(DEPTH);
  localparam logic signed [STEP_W-1:0] ONE  = STEP_W'(1);
  localparam logic signed [STEP_W-1:0] ZERO = '0;

  logic [4:0]             in_valid, in_ready, push, pop;
  logic [4:0][FLIT_W-1:0] in_flit;
  logic [4:0]             head_valid;
  logic [4:0][FLIT_W-1:0] head_flit;
  logic [4:0][2:0]        target;
  logic [4:0][FLIT_W-1:0] upd_flit;

  logic [4:0]             out_valid_reg, out_ready, can_load;
  logic [3:0][FLIT_W-1:0] out_flit_reg;
  logic [DATA_W-1:0]      loc_payload_reg;
  logic [4:0][2:0]        ptr_reg;
  logic [4:0]             gnt_valid;
  logic [4:0][2:0]        gnt_idx;

  // Route computation for locally injected packets
  int                d_int, alpha, beta;
  logic              neg, loc_drop;
  logic [STEP_W-1:0] loc_r1, loc_r2;

  always_comb begin
    loc_drop = (int'(loc_in_dst) >= N_NODES);
    neg      = 1'b0;
    d_int    = int'(loc_in_dst) - int'(router_name);
    if (d_int < 0) d_int = d_int + N_NODES;
    if (d_int > (N_NODES >> 1)) begin
      d_int = N_NODES - d_int;
      neg   = 1'b1;
    end
    beta  = d_int % S1;
    alpha = d_int / S1 - beta;
    // Rebalance so neither step count strays far past one generator's worth
    if (alpha < beta - S1) begin
      alpha = alpha + S1 + 1;
      beta  = beta - S1;
    end else if (alpha > S1) begin
      alpha = alpha - (S1 + 1);
      beta  = beta + S1;
    end
    loc_r1 = STEP_W'(neg ? -alpha : alpha);
    loc_r2 = STEP_W'(neg ? -beta : beta);
  end

  assign in_valid      = {loc_in_valid, link_in_valid};
  assign in_flit[4]    = {loc_r1, loc_r2, loc_in_payload};
  assign push          = in_valid & in_ready & {~loc_drop, 4'hf};
  assign loc_in_ready  = in_ready[4];
  assign link_in_ready = in_ready[3:0];

  for (genvar gi = 0; gi < 4; gi++) begin : g_link_io
    assign in_flit[gi] = link_in_flit[gi*FLIT_W +: FLIT_W];
    assign link_out_flit[gi*FLIT_W +: FLIT_W] = out_flit_reg[gi];
  end

  // Input FIFOs: array storage plus a registered head entry that feeds arbitration
  for (genvar gi = 0; gi < 5; gi++) begin : g_fifo
    logic [FLIT_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]       mem_count_reg, occ;
    logic              head_valid_reg, load_head;
    logic [FLIT_W-1:0] head_reg;

    assign occ          = mem_count_reg + {{AW{1'b0}}, head_valid_reg};
    assign in_ready[gi] = (occ < (AW+1)'(DEPTH));
    assign load_head    = (mem_count_reg != '0) && (!head_valid_reg || pop[gi]);
    assign head_valid[gi] = head_valid_reg;
    assign head_flit[gi]  = head_reg;

    always_ff @(posedge clk) begin
      if (push[gi]) mem[wr_ptr_reg] <= in_flit[gi];
      if (load_head) head_reg <= mem[rd_ptr_reg];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr_reg     <= '0;
        rd_ptr_reg     <= '0;
        mem_count_reg  <= '0;
        head_valid_reg <= 1'b0;
      end else begin
        if (push[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (load_head) begin
          rd_ptr_reg     <= rd_ptr_reg + 1'b1;
          head_valid_reg <= 1'b1;
        end else if (pop[gi]) begin
          head_valid_reg <= 1'b0;
        end
        mem_count_reg <= mem_count_reg + {{AW{1'b0}}, push[gi]} - {{AW{1'b0}}, load_head};
      end
    end
  end

`ifdef ADAPTIVE_ROUTE_EN
  logic [4:0] out_blocked;
  assign out_blocked = out_valid_reg & ~out_ready;
`endif

  // Head decode: pick the output and the decremented step counters
  for (genvar gi = 0; gi < 5; gi++) begin : g_decode
    logic signed [STEP_W-1:0] r1, r2;
    logic [DATA_W-1:0]        pay;
    logic [2:0]               tgt;
    logic [FLIT_W-1:0]        upd;

    assign r1  = head_flit[gi][FLIT_W-1 -: STEP_W];
    assign r2  = head_flit[gi][DATA_W +: STEP_W];
    assign pay = head_flit[gi][DATA_W-1:0];

    always_comb begin
      tgt = 3'd4;
      upd = head_flit[gi];
      if (r1 > ZERO) begin
        tgt = 3'd0;
        upd = {r1 - ONE, r2, pay};
      end else if (r1 < ZERO) begin
        tgt = 3'd2;
        upd = {r1 + ONE, r2, pay};
      end else if (r2 > ZERO) begin
        tgt = 3'd1;
        upd = {r1, r2 - ONE, pay};
      end else if (r2 < ZERO) begin
        tgt = 3'd3;
        upd = {r1, r2 + ONE, pay};
      end
`ifdef ADAPTIVE_ROUTE_EN
      if ((r1 != ZERO) && (r2 != ZERO) && out_blocked[tgt]) begin
        tgt = (r2 > ZERO) ? 3'd1 : 3'd3;
        upd = {r1, (r2 > ZERO) ? r2 - ONE : r2 + ONE, pay};
      end
`endif
    end

    assign target[gi]   = tgt;
    assign upd_flit[gi] = upd;
  end

  // Round-robin arbitration per output; a head targets one output, so pops never collide
  assign out_ready = {loc_out_ready, link_out_ready};
  assign can_load  = ~out_valid_reg | out_ready;

  int idx;
  always_comb begin
    gnt_valid = '0;
    gnt_idx   = '0;
    pop       = '0;
    idx       = 0;
    for (int o = 0; o < 5; o++) begin
      for (int k = 0; k < 5; k++) begin
        idx = int'(ptr_reg[o]) + k;
        if (idx >= 5) idx = idx - 5;
        if (can_load[o] && !gnt_valid[o] && head_valid[idx] && (target[idx] == 3'(o))) begin
          gnt_valid[o] = 1'b1;
          gnt_idx[o]   = 3'(idx);
          pop[idx]     = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg   <= '0;
      out_flit_reg    <= '0;
      loc_payload_reg <= '0;
      ptr_reg         <= '0;
    end else begin
      for (int o = 0; o < 5; o++) begin
        if (gnt_valid[o]) begin
          out_valid_reg[o] <= 1'b1;
          ptr_reg[o]       <= (gnt_idx[o] == 3'd4) ? 3'd0 : gnt_idx[o] + 3'd1;
        end else if (out_ready[o]) begin
          out_valid_reg[o] <= 1'b0;
        end
      end
      for (int o = 0; o < 4; o++) begin
        if (gnt_valid[o]) out_flit_reg[o] <= upd_flit[gnt_idx[o]];
      end
      if (gnt_valid[4]) loc_payload_reg <= upd_flit[gnt_idx[4]][DATA_W-1:0];
    end
  end

  assign link_out_valid  = out_valid_reg[3:0];
  assign loc_out_valid   = out_valid_reg[4];
  assign loc_out_payload = loc_payload_reg;

endmodule

// File: tb/tb_circulant_router_param.sv
// Scoreboard bench for circulant_router_param: a reference route model fills per-output
// expectation queues at acceptance; a negedge monitor matches every output transfer.
module tb_circulant_router_param;
  localparam int N = 81, S1 = 6, NODE_W = 7, STEP_W = 7, DATA_W = 8, DEPTH = 4;
  localparam int FLIT_W = 2*STEP_W + DATA_W;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic [NODE_W-1:0]   router_name = '0;
  logic                loc_in_valid = 1'b0, loc_in_ready;
  logic [NODE_W-1:0]   loc_in_dst = '0;
  logic [DATA_W-1:0]   loc_in_payload = '0;
  logic                lv [4];
  logic [FLIT_W-1:0]   lf [4];
  logic [3:0]          link_in_valid, link_in_ready, link_out_valid, link_out_ready;
  logic [4*FLIT_W-1:0] link_in_flit, link_out_flit;
  logic                loc_out_valid, loc_out_ready;
  logic [DATA_W-1:0]   loc_out_payload;
  logic [4:0]          out_rdy = 5'h1f;

  assign link_in_valid  = {lv[3], lv[2], lv[1], lv[0]};
  assign link_in_flit   = {lf[3], lf[2], lf[1], lf[0]};
  assign link_out_ready = out_rdy[3:0];
  assign loc_out_ready  = out_rdy[4];

  circulant_router_param dut (
    .clk(clk), .rst(rst), .router_name(router_name),
    .loc_in_valid(loc_in_valid), .loc_in_ready(loc_in_ready),
    .loc_in_dst(loc_in_dst), .loc_in_payload(loc_in_payload),
    .link_in_valid(link_in_valid), .link_in_ready(link_in_ready), .link_in_flit(link_in_flit),
    .link_out_valid(link_out_valid), .link_out_ready(link_out_ready), .link_out_flit(link_out_flit),
    .loc_out_valid(loc_out_valid), .loc_out_ready(loc_out_ready), .loc_out_payload(loc_out_payload)
  );

  typedef struct { logic [FLIT_W-1:0] flit; int src; } exp_t;
  exp_t exp_q [5][$];
  int   ej_log [$];
  int   tests = 0, fails = 0, tag_cnt = 0;
  bit   rdone;

  // Reference model: shortest split of the ring distance into S1 and S1+1 hops
  function automatic void model_route(input int dst, input int name, output int r1, output int r2);
    int d, a, b;
    bit neg;
    d = ((dst - name) % N + N) % N;
    neg = (d > N / 2);
    if (neg) d = N - d;
    b = d % S1;
    a = d / S1 - b;
    if (a < b - S1) begin a = a + S1 + 1; b = b - S1; end
    else if (a > S1) begin a = a - S1 - 1; b = b + S1; end
    r1 = neg ? -a : a;
    r2 = neg ? -b : b;
  endfunction

  function automatic int model_hop(input int r1, input int r2, output int n1, output int n2);
    n1 = r1; n2 = r2;
    if (r1 > 0) begin n1 = r1 - 1; return 0; end
    if (r1 < 0) begin n1 = r1 + 1; return 2; end
    if (r2 > 0) begin n2 = r2 - 1; return 1; end
    if (r2 < 0) begin n2 = r2 + 1; return 3; end
    return 4;
  endfunction

  function automatic logic [FLIT_W-1:0] pack(input int r1, input int r2, input logic [DATA_W-1:0] p);
    logic [STEP_W-1:0] a, b;
    a = r1[STEP_W-1:0];
    b = r2[STEP_W-1:0];
    return {a, b, p};
  endfunction

  function automatic logic [DATA_W-1:0] next_tag();
    tag_cnt++;
    return tag_cnt[DATA_W-1:0];
  endfunction

  function automatic logic outv(input int o);
    if (o == 4) return loc_out_valid;
    return link_out_valid[o];
  endfunction

  function automatic logic [FLIT_W-1:0] outf(input int o);
    if (o == 4) return {{(2*STEP_W){1'b0}}, loc_out_payload};
    return link_out_flit[o*FLIT_W +: FLIT_W];
  endfunction

  function automatic int q_total();
    int t = 0;
    for (int o = 0; o < 5; o++) t += exp_q[o].size();
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input int src, input int r1, input int r2, input logic [DATA_W-1:0] p);
    int n1, n2, o;
    exp_t e;
    o = model_hop(r1, r2, n1, n2);
    e.flit = pack(n1, n2, p);
    e.src  = src;
    exp_q[o].push_back(e);
  endtask

  // Offers one packet on a port; returns at posedge+1 with ok set if it was accepted
  task automatic send(input int port, input int dst, input int r1, input int r2,
                      input logic [DATA_W-1:0] p, input int limit, output bit ok);
    int  m1, m2;
    bit  rdy;
    ok = 1'b0;
    if (port == 4) begin
      loc_in_valid = 1'b1; loc_in_dst = dst[NODE_W-1:0]; loc_in_payload = p;
    end else begin
      lv[port] = 1'b1; lf[port] = pack(r1, r2, p);
    end
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      rdy = (port == 4) ? loc_in_ready : link_in_ready[port];
      if (rdy) begin
        ok = 1'b1;
        if (port != 4) push_exp(port, r1, r2, p);
        else if (dst < N) begin
          model_route(dst, int'(router_name), m1, m2);
          push_exp(port, m1, m2, p);
        end
      end
      @(posedge clk); #1;
      if (ok) break;
    end
    if (port == 4) loc_in_valid = 1'b0;
    else lv[port] = 1'b0;
  endtask

  task automatic lat_check(input string name, input int o, input logic [FLIT_W-1:0] req);
    @(negedge clk);
    @(negedge clk);
    check({name, "_early"}, outv(o), 1'b0);
    @(negedge clk);
    check({name, "_valid"}, outv(o), 1'b1);
    check({name, "_flit"}, outf(o), req);
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name, input int limit);
    int c = 0;
    while (q_total() > 0 && c < limit) begin @(posedge clk); c++; end
    #1;
    check({name, "_drain"}, q_total(), 0);
  endtask

  task automatic rand_driver(input int p);
    bit ok;
    int d, a, b;
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      d = $urandom_range(0, N + 3);
      a = $urandom_range(0, 6) - 3;
      b = $urandom_range(0, 6) - 3;
      send(p, d, a, b, next_tag(), 300, ok);
      check("rand_accept", ok, 1'b1);
    end
  endtask

  // Monitor: every output transfer must match the oldest same-source expectation
  always @(negedge clk) begin
    if (!rst) begin
      for (int o = 0; o < 5; o++) begin
        if (outv(o) && out_rdy[o]) begin
          int j;
          bit bad;
          logic [FLIT_W-1:0] f;
          f = outf(o);
          j = -1;
          bad = 1'b0;
          for (int k = 0; k < exp_q[o].size(); k++)
            if (j < 0 && exp_q[o][k].flit[DATA_W-1:0] == f[DATA_W-1:0]) j = k;
          tests++;
          if (j < 0) begin
            fails++;
            $display("FAIL out%0d_unexpected: got %h, required no transfer", o, f);
          end else begin
            if (o < 4 && exp_q[o][j].flit != f) bad = 1'b1;
            for (int k = 0; k < j; k++) if (exp_q[o][k].src == exp_q[o][j].src) bad = 1'b1;
            if (bad) begin
              fails++;
              $display("FAIL out%0d_flit: got %h, required %h (src %0d, order)", o, f,
                       exp_q[o][j].flit, exp_q[o][j].src);
            end else begin
              $display("[TB] out%0d flit %h from src %0d", o, f, exp_q[o][j].src);
            end
            if (o == 4) ej_log.push_back(exp_q[o][j].src);
            exp_q[o].delete(j);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int acc;
    logic [DATA_W-1:0] first_tag;
    for (int i = 0; i < 4; i++) begin lv[i] = 1'b0; lf[i] = '0; end
    rdone = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_link_out_valid", link_out_valid, 4'h0);
    check("rst_loc_out_valid", loc_out_valid, 1'b0);
    check("rst_link_out_flit", link_out_flit, '0);
    check("rst_loc_out_payload", loc_out_payload, '0);
    check("rst_link_in_ready", link_in_ready, 4'hf);
    check("rst_loc_in_ready", loc_in_ready, 1'b1);
    @(posedge clk); #1;

    // Directed routing and latency
    send(4, 13, 0, 0, 8'hA5, 10, ok);
    lat_check("dst13", 0, pack(0, 1, 8'hA5));
    send(4, 80, 0, 0, 8'h5A, 10, ok);
    lat_check("dst80", 0, pack(0, -1, 8'h5A));
    send(0, 0, 0, -1, 8'h5B, 10, ok);
    lat_check("fwd_r2neg", 3, pack(0, 0, 8'h5B));
    send(4, 0, 0, 0, 8'h77, 10, ok);
    lat_check("loc_self", 4, pack(0, 0, 8'h77));
    send(1, 0, 0, 0, 8'h3C, 10, ok);
    lat_check("link1_eject", 4, pack(0, 0, 8'h3C));
    send(4, 90, 0, 0, 8'h11, 10, ok);
    check("drop_accept", ok, 1'b1);
    drain("directed", 50);

    // Two links contending for local ejection
    ej_log.delete();
    fork
      for (int i = 0; i < 8; i++) begin send(0, 0, 0, 0, next_tag(), 50, ok); end
      for (int i = 0; i < 8; i++) begin bit ok2; send(2, 0, 0, 0, next_tag(), 50, ok2); end
    join
    drain("alt", 100);
    check("alt_count", ej_log.size(), 16);
    for (int k = 1; k < 6 && k < ej_log.size(); k++)
      check("alt_order", ej_log[k] != ej_log[k-1], 1'b1);

    // Backpressure on out 0
    out_rdy = 5'b11110;
    acc = 0;
    first_tag = '0;
    for (int i = 0; i < 6; i++) begin
      logic [DATA_W-1:0] t;
      t = next_tag();
      if (i == 0) first_tag = t;
      send(4, 6, 0, 0, t, 8, ok);
      if (ok) acc++;
    end
    @(negedge clk);
    check("bp_accepted", acc, 5);
    check("bp_loc_in_ready", loc_in_ready, 1'b0);
    check("bp_held_valid", link_out_valid[0], 1'b1);
    check("bp_held_flit", link_out_flit[FLIT_W-1:0], pack(0, 0, first_tag));
    @(posedge clk); #1;
    out_rdy = 5'h1f;
    drain("bp", 50);

    // Reset with flits buffered
    out_rdy = 5'b11110;
    for (int i = 0; i < 3; i++) send(4, 6, 0, 0, next_tag(), 8, ok);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int o = 0; o < 5; o++) exp_q[o].delete();
    @(negedge clk);
    check("mid_rst_link_out_valid", link_out_valid, 4'h0);
    check("mid_rst_loc_out_valid", loc_out_valid, 1'b0);
    check("mid_rst_link_in_ready", link_in_ready, 4'hf);
    check("mid_rst_loc_in_ready", loc_in_ready, 1'b1);
    @(posedge clk); #1;
    out_rdy = 5'h1f;
    send(4, 13, 0, 0, 8'hC3, 10, ok);
    lat_check("post_rst", 0, pack(0, 1, 8'hC3));
    drain("post_rst", 50);

    // Randomized traffic at a different node with random output backpressure
    router_name = 7'd37;
    @(posedge clk); #1;
    fork
      begin
        while (!rdone) begin out_rdy = 5'($urandom); @(posedge clk); #1; end
      end
      begin
        fork
          rand_driver(0);
          rand_driver(1);
          rand_driver(2);
          rand_driver(3);
          rand_driver(4);
        join
        rdone = 1'b1;
      end
    join
    out_rdy = 5'h1f;
    drain("rand", 500);
    for (int o = 0; o < 5; o++) check("rand_queue_empty", exp_q[o].size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
